// File: rtl/sram_l1_pkg.sv
// Shared widths, FSM state encoding and helpers for the L1 SRAM request controller.
package sram_l1_pkg;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  typedef enum logic [2:0] {
    WARMUP,
    IDLE,
    RD_WAIT,
    WR_HOLD,
    RESP,
    GAP
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/sram_l1_cnt.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
module sram_l1_cnt #(
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned RST_VAL = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);
  assign zero = (count == '0);

  always_ff @(posedge clk) begin
    if (rst)
      count <= CNT_W'(RST_VAL);
    else if (load)
      count <= load_val;
    else if (!zero)
      count <= count - CNT_W'(1);
  end
endmodule

// File: rtl/sram_l1_req_ctrl.sv
// Single-outstanding request controller in front of an SRAM macro wrapper:
// warmup, timed write hold, read wait with timeout, one-cycle response, csb gap.
module sram_l1_req_ctrl
  import sram_l1_pkg::*;
#(
  parameter int unsigned WARMUP_CYC     = 16,
  parameter int unsigned WR_HOLD_CYC    = 8,
  parameter int unsigned RD_TIMEOUT_CYC = 32,
  parameter int unsigned GAP_CYC        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  output logic              sram_we,
  output logic              sram_csb,
  output logic [MASK_W-1:0] sram_wmask,
  input  logic [DATA_W-1:0] sram_dout,
  input  logic              sram_data_ready
);
  localparam int unsigned CNT_MAX = max_u(max_u(WARMUP_CYC, WR_HOLD_CYC),
                                          max_u(max_u(RD_TIMEOUT_CYC, GAP_CYC), 1));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e            state, state_n;
  logic              cnt_load, cnt_zero, done;
  logic [CNT_W-1:0]  cnt_val, cnt;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] din_n, rdata_n;
  logic [MASK_W-1:0] wmask_n;
  logic              we_n, csb_n, err_n;

  sram_l1_cnt #(
    .CNT_W  (CNT_W),
    .RST_VAL(WARMUP_CYC)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(cnt_val),
    .count   (cnt),
    .zero    (cnt_zero)
  );

  // Counter is loaded with N on entry; the state ends on the cycle it reads 1,
  // so each timed state occupies exactly N cycles.
  assign done      = cnt_zero || (cnt == CNT_W'(1));
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_n = state;
    addr_n  = sram_addr;
    din_n   = sram_din;
    wmask_n = sram_wmask;
    we_n    = sram_we;
    csb_n   = sram_csb;
    rdata_n = rsp_rdata;
    err_n   = rsp_err;
    case (state)
      WARMUP: if (done) state_n = IDLE;
      IDLE: begin
        if (req_valid) begin
          addr_n = req_addr;
          csb_n  = 1'b0;
          if (req_write) begin
            din_n   = req_wdata;
            wmask_n = req_wmask;
            we_n    = 1'b0;
            state_n = WR_HOLD;
          end else begin
            we_n    = 1'b1;
            state_n = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (sram_data_ready || done) begin
          rdata_n = sram_data_ready ? sram_dout : '0;
          err_n   = !sram_data_ready;
          state_n = RESP;
        end
      end
      WR_HOLD: begin
        if (done) begin
          rdata_n = '0;
          err_n   = 1'b0;
          state_n = RESP;
        end
      end
      RESP: state_n = GAP;
      GAP:  if (done) state_n = IDLE;
      default: state_n = WARMUP;
    endcase

    if (state_n == RESP) begin
      csb_n   = 1'b1;
      we_n    = 1'b1;
      wmask_n = '0;
    end

    cnt_load = (state_n != state);
    case (state_n)
      WARMUP:  cnt_val = CNT_W'(WARMUP_CYC);
      RD_WAIT: cnt_val = CNT_W'(RD_TIMEOUT_CYC);
      WR_HOLD: cnt_val = CNT_W'(WR_HOLD_CYC);
      GAP:     cnt_val = CNT_W'(GAP_CYC);
      default: cnt_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WARMUP;
      sram_addr  <= '0;
      sram_din   <= '0;
      sram_wmask <= '0;
      sram_we    <= 1'b1;
      sram_csb   <= 1'b1;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state      <= state_n;
      sram_addr  <= addr_n;
      sram_din   <= din_n;
      sram_wmask <= wmask_n;
      sram_we    <= we_n;
      sram_csb   <= csb_n;
      rsp_rdata  <= rdata_n;
      rsp_err    <= err_n;
    end
  end
endmodule

// File: tb/tb_sram_l1_req_ctrl.sv
// Directed bench for sram_l1_req_ctrl with the SRAM wrapper responses driven inline.
module tb_sram_l1_req_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [8:0]  sram_addr;
  logic [31:0] sram_din, sram_dout;
  logic        sram_we, sram_csb, sram_data_ready;
  logic [3:0]  sram_wmask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_l1_req_ctrl #(
    .WARMUP_CYC    (16),
    .WR_HOLD_CYC   (8),
    .RD_TIMEOUT_CYC(32),
    .GAP_CYC       (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_wmask      (req_wmask),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .sram_addr      (sram_addr),
    .sram_din       (sram_din),
    .sram_we        (sram_we),
    .sram_csb       (sram_csb),
    .sram_wmask     (sram_wmask),
    .sram_dout      (sram_dout),
    .sram_data_ready(sram_data_ready)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_req_ready"}, 32'(req_ready), 32'd0);
    check({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({pfx, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({pfx, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({pfx, "_csb"}, 32'(sram_csb), 32'd1);
    check({pfx, "_we"}, 32'(sram_we), 32'd1);
    check({pfx, "_wmask"}, 32'(sram_wmask), 32'd0);
    check({pfx, "_addr"}, 32'(sram_addr), 32'd0);
    check({pfx, "_din"}, sram_din, 32'd0);
  endtask

  initial begin
    int n;
    int cnt;
    logic bad;
    logic seen;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; sram_dout = '0; sram_data_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    check_reset_vals("rst");

    // Warmup with req_valid held high; the write is accepted as soon as ready rises
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h005;
    req_wdata = 32'hDEADBEEF; req_wmask = 4'hF;
    rst = 1'b0;
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (req_ready === 1'b1) break;
    end
    check("warmup_len", 32'(n), 32'd16);

    tick();
    req_valid = 1'b0;
    cnt = 0; bad = 1'b0;
    while (sram_csb === 1'b0 && cnt < 50) begin
      cnt++;
      if (sram_we !== 1'b0 || sram_addr !== 9'h005 || sram_din !== 32'hDEADBEEF ||
          sram_wmask !== 4'hF) bad = 1'b1;
      tick();
    end
    check("wr_hold_len", 32'(cnt), 32'd8);
    check("wr_pins_stable", 32'(bad), 32'd0);
    check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    check("wr_rsp_err", 32'(rsp_err), 32'd0);
    check("wr_rsp_rdata", rsp_rdata, 32'd0);
    check("wr_resp_wmask", 32'(sram_wmask), 32'd0);
    tick();
    check("wr_gap_rsp_valid", 32'(rsp_valid), 32'd0);
    check("wr_gap_din_hold", sram_din, 32'hDEADBEEF);
    wait_ready(n);
    check("wr_gap_to_idle", 32'(n), 32'd4);

    // Read with the wrapper answering on the 10th edge after issue
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h005;
    tick();
    req_valid = 1'b0;
    check("rd_csb", 32'(sram_csb), 32'd0);
    check("rd_we", 32'(sram_we), 32'd1);
    check("rd_addr", 32'(sram_addr), 32'h005);
    repeat (9) tick();
    check("rd_no_early_rsp", 32'(rsp_valid), 32'd0);
    sram_data_ready = 1'b1; sram_dout = 32'hDEADBEEF;
    tick();
    sram_data_ready = 1'b0; sram_dout = 32'h12345678;
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    check("rd_rsp_err", 32'(rsp_err), 32'd0);
    check("rd_resp_csb", 32'(sram_csb), 32'd1);

    // Stray data_ready during GAP must not produce anything
    tick();
    sram_data_ready = 1'b1; sram_dout = 32'h0BADF00D;
    tick();
    sram_data_ready = 1'b0;
    check("stray_rsp_valid", 32'(rsp_valid), 32'd0);
    check("stray_rdata_hold", rsp_rdata, 32'hDEADBEEF);
    wait_ready(n);

    // Read that never completes: timeout after 32 cycles with csb low
    req_valid = 1'b1; req_addr = 9'h01A;
    tick();
    req_valid = 1'b0;
    cnt = 0;
    while (sram_csb === 1'b0 && cnt < 60) begin
      cnt++;
      tick();
    end
    check("to_wait_len", 32'(cnt), 32'd32);
    check("to_rsp_valid", 32'(rsp_valid), 32'd1);
    check("to_rsp_err", 32'(rsp_err), 32'd1);
    check("to_rsp_rdata", rsp_rdata, 32'd0);
    wait_ready(n);

    // data_ready on the expiry edge wins over the timeout
    req_valid = 1'b1; req_addr = 9'h020;
    tick();
    req_valid = 1'b0;
    repeat (31) tick();
    check("tie_still_waiting", 32'(rsp_valid), 32'd0);
    sram_data_ready = 1'b1; sram_dout = 32'hCAFEF00D;
    tick();
    sram_data_ready = 1'b0;
    check("tie_rsp_valid", 32'(rsp_valid), 32'd1);
    check("tie_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
    check("tie_rsp_err", 32'(rsp_err), 32'd0);
    wait_ready(n);

    // Back-to-back reads with req_valid held: csb high over RESP, GAP and the IDLE accept cycle
    req_valid = 1'b1; req_addr = 9'h007;
    tick();
    req_addr = 9'h008;
    repeat (2) tick();
    sram_data_ready = 1'b1; sram_dout = 32'h11111111;
    tick();
    sram_data_ready = 1'b0;
    check("b2b_rd1_rdata", rsp_rdata, 32'h11111111);
    cnt = 0;
    while (sram_csb === 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
    req_valid = 1'b0;
    check("b2b_csb_high_len", 32'(cnt), 32'd6);
    check("b2b_rd2_addr", 32'(sram_addr), 32'h008);
    repeat (2) tick();
    sram_data_ready = 1'b1; sram_dout = 32'h22222222;
    tick();
    sram_data_ready = 1'b0;
    check("b2b_rd2_valid", 32'(rsp_valid), 32'd1);
    check("b2b_rd2_rdata", rsp_rdata, 32'h22222222);
    wait_ready(n);

    // Reset mid-read, then a late data_ready: access dropped, warmup restarts
    req_valid = 1'b1; req_addr = 9'h033;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_reset_vals("midrst");
    rst = 1'b0;
    sram_data_ready = 1'b1; sram_dout = 32'h55AA55AA;
    n = 0; seen = 1'b0;
    while (n < 40) begin
      tick();
      n++;
      sram_data_ready = 1'b0;
      if (rsp_valid === 1'b1) seen = 1'b1;
      if (req_ready === 1'b1) break;
    end
    check("midrst_warmup_len", 32'(n), 32'd16);
    check("midrst_no_rsp", 32'(seen), 32'd0);
    check("midrst_rdata", rsp_rdata, 32'd0);
    check("midrst_csb_idle", 32'(sram_csb), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
